// File: rtl/munoc_w_order_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Module  : munoc_w_order_scheduler_pkg
// Brief   : Shared widths and helpers for the NoC write-order scheduler.
// Revision: 1.0 - initial release
// ============================================================================
package munoc_w_order_scheduler_pkg;

    localparam int BW_AXI_ALEN = 8;

    typedef logic [BW_AXI_ALEN-1:0] axi_len_t;

    // Width of a 0..depth occupancy counter
    function automatic int pending_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/munoc_wsched_queue.sv
`default_nettype none
// ============================================================================
// Module  : munoc_wsched_queue
// Brief   : DEPTH-entry synchronous FIFO, head entry visible combinationally.
// Revision: 1.0 - initial release
// ============================================================================
module munoc_wsched_queue #(
    parameter int WIDTH = 12,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rstnn,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int                  c_aw    = $clog2(DEPTH);
    localparam logic [c_aw:0]       c_depth = (c_aw+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_aw-1:0]  r_wr_ptr;
    logic [c_aw-1:0]  r_rd_ptr;
    logic [c_aw:0]    r_count;
    logic             w_push;
    logic             w_pop;

    assign full   = (r_count == c_depth);
    assign empty  = (r_count == '0);
    assign count  = r_count;
    assign head   = r_mem[r_rd_ptr];
    assign w_push = push & ~full;
    assign w_pop  = pop & ~empty;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk or negedge rstnn) begin
        if (!rstnn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/munoc_w_order_scheduler.sv
`default_nettype none
// ============================================================================
// Module  : munoc_w_order_scheduler
// Brief   : Admits AXI W beats only for queued AW bursts, retires bursts by
//           beat count and flags WLAST / WID violations.
//           Option: MUNOC_WSCHED_WLAST_REGEN_EN regenerates m_wlast from count.
// Revision: 1.0 - initial release
// ============================================================================
module munoc_w_order_scheduler
    import munoc_w_order_scheduler_pkg::*;
#(
    parameter int BW_ID = 4,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rstnn,
    input  logic                     clear,
    input  logic                     s_awvalid,
    output logic                     s_awready,
    input  logic [BW_ID-1:0]         s_awid,
    input  logic [BW_AXI_ALEN-1:0]   s_awlen,
    output logic                     m_awvalid,
    input  logic                     m_awready,
    input  logic                     s_wvalid,
    output logic                     s_wready,
    input  logic [BW_ID-1:0]         s_wid,
    input  logic                     s_wlast,
    output logic                     m_wvalid,
    input  logic                     m_wready,
    output logic                     m_wlast,
    output logic [$clog2(DEPTH):0]   pending,
    output logic                     err_wlast,
    output logic                     err_wid,
    output logic [1:0]               err_sticky
);

    localparam int c_entry_w = BW_ID + BW_AXI_ALEN;
    localparam int c_len_lsb = 0;
    localparam int c_id_lsb  = BW_AXI_ALEN;

    logic [c_entry_w-1:0]  w_head;
    logic [BW_ID-1:0]      w_head_id;
    axi_len_t              w_head_len;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_beat;
    logic                  w_last;
    axi_len_t              r_cnt;
    logic                  r_err_wlast;
    logic                  r_err_wid;
    logic [1:0]            r_sticky;

    assign w_head_id  = w_head[c_id_lsb +: BW_ID];
    assign w_head_len = w_head[c_len_lsb +: BW_AXI_ALEN];

    // No pass-through when full, no bypass when empty
    assign m_awvalid = s_awvalid & ~w_full;
    assign s_awready = m_awready & ~w_full;
    assign w_push    = s_awvalid & s_awready;

    assign m_wvalid  = s_wvalid & ~w_empty;
    assign s_wready  = m_wready & ~w_empty;
    assign w_beat    = s_wvalid & s_wready;
    assign w_last    = (r_cnt == w_head_len);
    assign w_pop     = w_beat & w_last;

`ifdef MUNOC_WSCHED_WLAST_REGEN_EN
    assign m_wlast = w_last & ~w_empty;
`else
    assign m_wlast = s_wlast;
`endif

    munoc_wsched_queue #(
        .WIDTH (c_entry_w),
        .DEPTH (DEPTH)
    ) u_queue (
        .clk       (clk),
        .rstnn     (rstnn),
        .push      (w_push),
        .push_data ({s_awid, s_awlen}),
        .pop       (w_pop),
        .head      (w_head),
        .full      (w_full),
        .empty     (w_empty),
        .count     (pending)
    );

    always_ff @(posedge clk or negedge rstnn) begin
        if (!rstnn) begin
            r_cnt       <= '0;
            r_err_wlast <= 1'b0;
            r_err_wid   <= 1'b0;
            r_sticky    <= 2'b00;
        end else begin
            if (w_beat) begin
                r_cnt <= w_last ? '0 : r_cnt + 1'b1;
            end
            r_err_wlast <= w_beat & (s_wlast != w_last);
            r_err_wid   <= w_beat & (s_wid != w_head_id);
            // A pulse arriving together with clear keeps its flag set
            r_sticky    <= (r_sticky & ~{2{clear}}) | {r_err_wid, r_err_wlast};
        end
    end

    assign err_wlast  = r_err_wlast;
    assign err_wid    = r_err_wid;
    assign err_sticky = r_sticky;

endmodule
`default_nettype wire
